vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator and colour output stage. It replaces the fixed-640x480 `VGA` top-level timing logic. It derives a pixel-clock enable from the system clock and runs horizontal and vertical counters. It publishes the current pixel coordinate to the game renderer, then registers the returned colour, blanked outside the active area, onto `vgaRed/vgaGreen/vgaBlue`, aligned with `Hsync/Vsync`.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 38 +++
 rtl/vga_pix_ce_div.sv | 25 ++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, colour widths and test-pattern bar helper
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 4;

    localparam int RED_W_DEF = 3;
    localparam int GRN_W_DEF = 3;
    localparam int BLU_W_DEF = 2;

    // Eight vertical bars across the visible line
    localparam int BAR_W = 3;

    function automatic logic [BAR_W-1:0] bar_index(input int h, input int h_active);
        return BAR_W'((h * (1 << BAR_W)) / h_active);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: renderer-facing coordinate/colour bus plus the VGA pins
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int X_W   = $clog2(H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF),
    parameter int Y_W   = $clog2(V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF),
    parameter int RED_W = RED_W_DEF,
    parameter int GRN_W = GRN_W_DEF,
    parameter int BLU_W = BLU_W_DEF
);

    logic [RED_W-1:0] pix_r;
    logic [GRN_W-1:0] pix_g;
    logic [BLU_W-1:0] pix_b;
    logic             test_en;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic             pix_req;
    logic             frame_start;
    logic [RED_W-1:0] vgaRed;
    logic [GRN_W-1:0] vgaGreen;
    logic [BLU_W-1:0] vgaBlue;
    logic             Hsync;
    logic             Vsync;

    // Timing generator side
    modport master (
        input  pix_r, pix_g, pix_b, test_en,
        output pix_x, pix_y, pix_req, frame_start, vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
    );

    // Renderer / display side
    modport slave (
        output pix_r, pix_g, pix_b, test_en,
        input  pix_x, pix_y, pix_req, frame_start, vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
    );

endinterface

// File: rtl/vga_pix_ce_div.sv
// vga_pix_ce_div: pixel-clock enable, one clk high out of every CLK_DIV
module vga_pix_ce_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_ce
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] div_cnt_q, div_cnt_d;

    // With CLK_DIV=1 the counter is pinned at 0, so pix_ce is constantly 1
    assign pix_ce = div_cnt_q == W'(CLK_DIV - 1);

    // Wrap the divider at CLK_DIV-1
    always_comb div_cnt_d = pix_ce ? '0 : div_cnt_q + 1'b1;

    // Divider register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync decode and registered colour output.
// Define VGA_TEST_PATTERN_EN to add the internal 8-bar test pattern selected by test_en.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int RED_W    = RED_W_DEF,
    parameter int GRN_W    = GRN_W_DEF,
    parameter int BLU_W    = BLU_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W      = $clog2(H_TOTAL);
    localparam int Y_W      = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    logic             pix_ce, h_last, v_last, active, hs_c, vs_c, frame_start;
    logic [X_W-1:0]   h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]   v_cnt_q, v_cnt_d;
    logic [RED_W-1:0] src_r, red_q, red_d;
    logic [GRN_W-1:0] src_g, grn_q, grn_d;
    logic [BLU_W-1:0] src_b, blu_q, blu_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;

    vga_pix_ce_div #(.CLK_DIV(CLK_DIV)) u_pix_ce_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce)
    );

    // Decode the current raster position
    always_comb begin
        h_last      = h_cnt_q == X_W'(H_TOTAL - 1);
        v_last      = v_cnt_q == Y_W'(V_TOTAL - 1);
        active      = int'(h_cnt_q) < H_ACTIVE && int'(v_cnt_q) < V_ACTIVE;
        hs_c        = int'(h_cnt_q) >= HS_START && int'(h_cnt_q) < HS_START + H_SYNC;
        vs_c        = int'(v_cnt_q) >= VS_START && int'(v_cnt_q) < VS_START + V_SYNC;
        frame_start = pix_ce && h_last && v_last;
    end

`ifdef VGA_TEST_PATTERN_EN
    logic             tp_mode_q, tp_mode_d;
    logic [BAR_W-1:0] bar;

    // Pick bars or renderer colour; the mode only changes at a frame boundary
    always_comb begin
        tp_mode_d = frame_start ? bus.test_en : tp_mode_q;
        bar       = bar_index(int'(h_cnt_q), H_ACTIVE);
        src_r     = tp_mode_q ? {RED_W{bar[2]}} : bus.pix_r;
        src_g     = tp_mode_q ? {GRN_W{bar[1]}} : bus.pix_g;
        src_b     = tp_mode_q ? {BLU_W{bar[0]}} : bus.pix_b;
    end

    // Test-pattern mode register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tp_mode_q <= 1'b0;
        else        tp_mode_q <= tp_mode_d;
`else
    // Renderer colour is the only source
    always_comb begin
        src_r = bus.pix_r;
        src_g = bus.pix_g;
        src_b = bus.pix_b;
    end
`endif

    // Advance counters and capture blanked colour/sync once per pixel
    always_comb begin
        h_cnt_d = pix_ce ? (h_last ? '0 : h_cnt_q + 1'b1) : h_cnt_q;
        v_cnt_d = (pix_ce && h_last) ? (v_last ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
        red_d   = pix_ce ? (active ? src_r : '0) : red_q;
        grn_d   = pix_ce ? (active ? src_g : '0) : grn_q;
        blu_d   = pix_ce ? (active ? src_b : '0) : blu_q;
        hsync_d = pix_ce ? (hs_c ? H_POL : ~H_POL) : hsync_q;
        vsync_d = pix_ce ? (vs_c ? V_POL : ~V_POL) : vsync_q;
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end

    assign bus.pix_x       = h_cnt_q;
    assign bus.pix_y       = v_cnt_q;
    assign bus.pix_req     = pix_ce && active;
    assign bus.frame_start = frame_start;
    assign bus.vgaRed      = red_q;
    assign bus.vgaGreen    = grn_q;
    assign bus.vgaBlue     = blu_q;
    assign bus.Hsync       = hsync_q;
    assign bus.Vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors on two small-raster instances (CLK_DIV 1 and 3)
module tb_vga_timing_gen;

    typedef struct packed {
        logic [3:0] x;
        logic [2:0] y;
        logic       req;
        logic       fs;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } obs_t;

    typedef struct {
        int   cyc;
        bit   dut_b;
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    obs_t oa, ob;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(4), .Y_W(3), .RED_W(3), .GRN_W(3), .BLU_W(2)) bus_a ();
    vga_timing_gen_if #(.X_W(4), .Y_W(3), .RED_W(3), .GRN_W(3), .BLU_W(2)) bus_b ();

    // Renderer: red = x, green = y, blue fixed
    assign bus_a.pix_r = bus_a.pix_x[2:0];
    assign bus_a.pix_g = bus_a.pix_y;
    assign bus_a.pix_b = 2'd2;
    assign bus_b.pix_r = bus_b.pix_x[2:0];
    assign bus_b.pix_g = bus_b.pix_y;
    assign bus_b.pix_b = 2'd2;

    // A: 12x7 raster, CLK_DIV=1, active-low syncs
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1),
        .RED_W(3), .GRN_W(3), .BLU_W(2)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    // B: same raster, CLK_DIV=3, active-high syncs
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(3),
        .RED_W(3), .GRN_W(3), .BLU_W(2)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign oa = {bus_a.pix_x, bus_a.pix_y, bus_a.pix_req, bus_a.frame_start,
                 bus_a.vgaRed, bus_a.vgaGreen, bus_a.vgaBlue, bus_a.Hsync, bus_a.Vsync};
    assign ob = {bus_b.pix_x, bus_b.pix_y, bus_b.pix_req, bus_b.frame_start,
                 bus_b.vgaRed, bus_b.vgaGreen, bus_b.vgaBlue, bus_b.Hsync, bus_b.Vsync};

    // clk edges since reset release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic vec_t mk(int c, bit d, int x, int y, int req, int fs,
                                int r, int g, int b, int hs, int vs);
        vec_t t;
        t.cyc   = c;
        t.dut_b = d;
        t.e     = {4'(x), 3'(y), 1'(req), 1'(fs), 3'(r), 3'(g), 2'(b), 1'(hs), 1'(vs)};
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_vec(string tag, vec_t t);
        obs_t  o = t.dut_b ? ob : oa;
        string p = $sformatf("%s.%s", t.dut_b ? "B" : "A", tag);
        chk({p, ".pix_x"}, 32'(o.x), 32'(t.e.x));
        chk({p, ".pix_y"}, 32'(o.y), 32'(t.e.y));
        chk({p, ".pix_req"}, 32'(o.req), 32'(t.e.req));
        chk({p, ".frame_start"}, 32'(o.fs), 32'(t.e.fs));
        chk({p, ".red"}, 32'(o.r), 32'(t.e.r));
        chk({p, ".green"}, 32'(o.g), 32'(t.e.g));
        chk({p, ".blue"}, 32'(o.b), 32'(t.e.b));
        chk({p, ".Hsync"}, 32'(o.hs), 32'(t.e.hs));
        chk({p, ".Vsync"}, 32'(o.vs), 32'(t.e.vs));
    endtask

    task automatic wait_cyc(int c);
        int guard = 0;
        while (cyc < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("reach_cyc_%0d", c), 32'(cyc), 32'(c));
    endtask

    initial begin
        int n_req, n_fs, n_hs, guard;
        bus_a.test_en = 1'b0;
        bus_b.test_en = 1'b0;
        //                cyc  B   x  y req fs  r  g  b hs vs
        vecs.push_back(mk(  0, 0,  0, 0, 1, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(  0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(  1, 0,  1, 0, 1, 0,  0, 0, 2, 1, 1));
        vecs.push_back(mk(  2, 1,  0, 0, 1, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(  3, 1,  1, 0, 0, 0,  0, 0, 2, 0, 0));
        vecs.push_back(mk(  5, 0,  5, 0, 1, 0,  4, 0, 2, 1, 1));
        vecs.push_back(mk(  8, 0,  8, 0, 0, 0,  7, 0, 2, 1, 1));
        vecs.push_back(mk(  8, 1,  2, 0, 1, 0,  1, 0, 2, 0, 0));
        vecs.push_back(mk(  9, 0,  9, 0, 0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 10, 0, 10, 0, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk( 11, 0, 11, 0, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk( 12, 0,  0, 1, 1, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 14, 0,  2, 1, 1, 0,  1, 1, 2, 1, 1));
        vecs.push_back(mk( 29, 1,  9, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 30, 1, 10, 0, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk( 36, 1,  0, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 48, 0,  0, 4, 0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 49, 0,  1, 4, 0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 60, 0,  0, 5, 0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 61, 0,  1, 5, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk( 72, 0,  0, 6, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk( 73, 0,  1, 6, 0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 83, 0, 11, 6, 0, 1,  0, 0, 0, 0, 1));
        vecs.push_back(mk( 84, 0,  0, 0, 1, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk( 85, 0,  1, 0, 1, 0,  0, 0, 2, 1, 1));
        vecs.push_back(mk( 86, 0,  2, 0, 1, 0,  1, 0, 2, 1, 1));
        vecs.push_back(mk(182, 1,  0, 5, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(183, 1,  1, 5, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(219, 1,  1, 6, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(251, 1, 11, 6, 0, 1,  0, 0, 0, 1, 0));
        vecs.push_back(mk(252, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        foreach (vecs[i]) begin
            wait_cyc(vecs[i].cyc);
            check_vec($sformatf("cyc%0d", vecs[i].cyc), vecs[i]);
        end

        // One full A frame: 32 requests, one frame_start; B sees two 6-clk Hsync pulses
        n_req = 0;
        n_fs  = 0;
        n_hs  = 0;
        for (int i = 0; i < 84; i++) begin
            n_req += int'(bus_a.pix_req);
            n_fs  += int'(bus_a.frame_start);
            n_hs  += int'(bus_b.Hsync);
            @(negedge clk);
        end
        chk("A.req_per_frame", 32'(n_req), 32'd32);
        chk("A.fs_per_frame", 32'(n_fs), 32'd1);
        chk("B.hsync_high_clks", 32'(n_hs), 32'd12);

        // Mid-frame reset on B at (5,2)
        guard = 0;
        while (!(bus_b.pix_x == 4'd5 && bus_b.pix_y == 3'd2) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("B.reach_5_2", 32'(guard < 400), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_vec("midrst", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_vec("midrst", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        while (!bus_b.frame_start && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("B.first_fs_after_rst", 32'(cyc), 32'd251);

`ifdef VGA_TEST_PATTERN_EN
        // test_en raised mid-frame only takes effect at the next frame
        wait_cyc(260);
        bus_a.test_en = 1'b1;
        wait_cyc(266);
        check_vec("tp_same_frame", mk(266, 0, 2, 1, 1, 0, 1, 1, 2, 1, 1));
        wait_cyc(338);
        check_vec("tp_bar1", mk(338, 0, 2, 0, 1, 0, 0, 0, 3, 1, 1));
        wait_cyc(341);
        check_vec("tp_bar4", mk(341, 0, 5, 0, 1, 0, 7, 0, 0, 1, 1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
